// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: T1-T4 bus cycle sequencer with registered bus strobes.
// Define READY_WAIT_EN to add the READY input, TW wait states and a MAX_WAIT timeout.
module bus_master_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_iom,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        ALE,
  output logic [19:0] Address,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
`ifdef READY_WAIT_EN
  input  logic        READY,
`endif
  inout  wire  [7:0]  Data
);
  localparam logic [2:0] TI = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4;
  logic [2:0] st, nx;
  logic       hs, strb, cap, to, wr_q, drv;
  logic [7:0] wd_q;
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("MAX_WAIT must be at least 1");
  end
  assign req_ready = !RESET && (st == TI || st == T4);
  assign hs = req_valid && req_ready;
  assign Data = drv ? wd_q : 8'hzz;
`ifdef READY_WAIT_EN
  localparam logic [2:0] TW = 3'd5;
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  // cnt numbers the current TW cycle (1..MAX_WAIT); the last one without READY aborts
  assign to = st == TW && !READY && cnt == CW'(MAX_WAIT);
  assign strb = nx == T2 || nx == T3 || nx == TW;
  always_comb
    nx = (st == TI || st == T4) ? (hs ? T1 : TI) :
         st == T1 ? T2 :
         st == T2 ? T3 :
         ((st == T3 || st == TW) && !READY && !to) ? TW : T4;
  always_ff @(posedge CLK)
    cnt <= (RESET || nx != TW) ? '0 : cnt + 1'b1;
`else
  assign to = 1'b0;
  assign strb = nx == T2 || nx == T3;
  always_comb
    nx = (st == TI || st == T4) ? (hs ? T1 : TI) :
         st == T1 ? T2 :
         st == T2 ? T3 : T4;
`endif
  // only T3/TW can lead into T4 apart from idle/T4 themselves
  assign cap = nx == T4 && st != TI && st != T4 && !to && !wr_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st        <= TI;
      ALE       <= 1'b0;
      Address   <= '0;
      IOM       <= 1'b0;
      RD        <= 1'b1;
      WR        <= 1'b1;
      drv       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
    end else begin
      st        <= nx;
      ALE       <= nx == T1;
      RD        <= !(strb && !wr_q);
      WR        <= !(strb && wr_q);
      drv       <= strb && wr_q;
      rsp_valid <= nx == T4;
      rsp_err   <= to;
      if (cap) rsp_rdata <= Data;
      if (hs) begin
        Address <= req_addr;
        IOM     <= req_iom;
        wr_q    <= req_write;
        wd_q    <= req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl: directed read/write/back-to-back/reset vectors against a small bus responder.
module tb_bus_master_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_iom = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, ALE, IOM, RD, WR;
  logic [7:0]  rsp_rdata;
  logic [19:0] Address;
  wire  [7:0]  Data;
  logic [7:0]  mem [16];
  int          checks = 0, fails = 0;

  bus_master_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .Address(Address), .IOM(IOM), .RD(RD), .WR(WR),
`ifdef READY_WAIT_EN
    .READY(1'b1),
`endif
    .Data(Data)
  );

  always #5 CLK = ~CLK;

  // responder: drives the addressed byte while RD is low, stores Data while WR is low
  assign Data = !RD ? mem[Address[3:0]] : 8'hzz;
  always @(posedge CLK) if (!WR) mem[Address[3:0]] <= Data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tk;
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic w, input logic iom, input logic [19:0] a, input logic [7:0] wd);
    req_valid = 1'b1;
    req_write = w;
    req_iom   = iom;
    req_addr  = a;
    req_wdata = wd;
  endtask

  always @(negedge CLK) begin
    chk("strobe_overlap", 32'(!RD && !WR), 0);
    chk("read_drive", 32'(!RD && dut.drv), 0);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h20 + 8'(i);
    mem[0] = 8'h11;
    mem[3] = 8'h5A;
    tk; tk;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ale", 32'(ALE), 0);
    chk("rst_addr", 32'(Address), 0);
    chk("rst_iom", 32'(IOM), 0);
    chk("rst_rdwr", 32'({RD, WR}), 2'b11);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_oe", 32'(dut.drv), 0);
    RESET = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 1);
    tk;
    chk("idle_stay_ale", 32'(ALE), 0);
    // read 0xFF03, iom=1
    req(1'b0, 1'b1, 20'hFF03, 8'h00);
    tk;
    req_valid = 1'b0;
    chk("rd_t1_ale", 32'(ALE), 1);
    chk("rd_t1_addr", 32'(Address), 32'hFF03);
    chk("rd_t1_iom", 32'(IOM), 1);
    chk("rd_t1_rdwr", 32'({RD, WR}), 2'b11);
    chk("rd_t1_ready", 32'(req_ready), 0);
    tk;
    chk("rd_t2_ale", 32'(ALE), 0);
    chk("rd_t2_rdwr", 32'({RD, WR}), 2'b01);
    tk;
    chk("rd_t3_rdwr", 32'({RD, WR}), 2'b01);
    chk("rd_t3_valid", 32'(rsp_valid), 0);
    tk;
    chk("rd_t4_valid", 32'(rsp_valid), 1);
    chk("rd_t4_rdata", 32'(rsp_rdata), 32'h5A);
    chk("rd_t4_err", 32'(rsp_err), 0);
    chk("rd_t4_rdwr", 32'({RD, WR}), 2'b11);
    chk("rd_t4_ready", 32'(req_ready), 1);
    tk;
    chk("rd_ti_valid", 32'(rsp_valid), 0);
    chk("rd_ti_addr_hold", 32'(Address), 32'hFF03);
    chk("rd_ti_iom_hold", 32'(IOM), 1);
    // write 0xC3 to 0xFF07, iom=0
    req(1'b1, 1'b0, 20'hFF07, 8'hC3);
    tk;
    req_valid = 1'b0;
    chk("wr_t1_ale", 32'(ALE), 1);
    chk("wr_t1_iom", 32'(IOM), 0);
    chk("wr_t1_oe", 32'(dut.drv), 0);
    tk;
    chk("wr_t2_rdwr", 32'({RD, WR}), 2'b10);
    chk("wr_t2_data", 32'(Data), 32'hC3);
    chk("wr_t2_oe", 32'(dut.drv), 1);
    tk;
    chk("wr_t3_rdwr", 32'({RD, WR}), 2'b10);
    chk("wr_t3_data", 32'(Data), 32'hC3);
    tk;
    chk("wr_t4_valid", 32'(rsp_valid), 1);
    chk("wr_t4_oe", 32'(dut.drv), 0);
    chk("wr_t4_rdwr", 32'({RD, WR}), 2'b11);
    chk("wr_t4_rdata_hold", 32'(rsp_rdata), 32'h5A);
    chk("wr_mem", 32'(mem[7]), 32'hC3);
    tk;
    // back-to-back: read 0xFF00 then write 0x77 to 0xFF01, req_valid held
    req(1'b0, 1'b1, 20'hFF00, 8'h00);
    tk;
    req(1'b1, 1'b0, 20'hFF01, 8'h77);
    chk("b2b_t1a_addr", 32'(Address), 32'hFF00);
    tk;
    chk("b2b_t2a_ignore", 32'(Address), 32'hFF00);
    chk("b2b_t2a_rdwr", 32'({RD, WR}), 2'b01);
    tk;
    chk("b2b_t3a_iom", 32'(IOM), 1);
    tk;
    chk("b2b_t4a_valid", 32'(rsp_valid), 1);
    chk("b2b_t4a_rdata", 32'(rsp_rdata), 32'h11);
    tk;
    req_valid = 1'b0;
    chk("b2b_t1b_ale", 32'(ALE), 1);
    chk("b2b_t1b_addr", 32'(Address), 32'hFF01);
    chk("b2b_t1b_valid", 32'(rsp_valid), 0);
    tk;
    chk("b2b_t2b_data", 32'(Data), 32'h77);
    tk;
    chk("b2b_t3b_rdwr", 32'({RD, WR}), 2'b10);
    tk;
    chk("b2b_t4b_valid", 32'(rsp_valid), 1);
    chk("b2b_mem", 32'(mem[1]), 32'h77);
    tk;
    chk("b2b_done_valid", 32'(rsp_valid), 0);
    // reset during T2 of a write
    req(1'b1, 1'b1, 20'hFF02, 8'hA5);
    tk;
    req_valid = 1'b0;
    tk;
    chk("mrst_t2_wr", 32'(WR), 0);
    RESET = 1'b1;
    tk;
    chk("mrst_wr", 32'(WR), 1);
    chk("mrst_oe", 32'(dut.drv), 0);
    chk("mrst_valid", 32'(rsp_valid), 0);
    chk("mrst_addr", 32'(Address), 0);
    chk("mrst_rdata", 32'(rsp_rdata), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    RESET = 1'b0;
    tk;
    chk("mrst_idle_ready", 32'(req_ready), 1);
    chk("mrst_idle_ale", 32'(ALE), 0);
    tk; tk;
    chk("mrst_no_valid", 32'(rsp_valid), 0);
    chk("mrst_idle_rdwr", 32'({RD, WR}), 2'b11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
